// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU vs MEM) with a per-register pending scoreboard.
// Latency: grant is combinational; commit is registered one edge after handshake; register updates on the following edge.
// Backpressure: the losing source sees READY low and must hold; decode sees STALL on RAW/WAW hazards.
module rf_writeback_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALU_VALID,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    input  logic [DATA_W-1:0] ALU_DATA,
    output logic              ALU_READY,
    input  logic              MEM_VALID,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              MEM_READY,
    input  logic              ISSUE,
    input  logic [ADDR_W-1:0] ISSUE_ADDR,
    input  logic [ADDR_W-1:0] SRC1_ADDR,
    input  logic [ADDR_W-1:0] SRC2_ADDR,
    output logic              STALL,
    output logic              RF_WRITE,
    output logic [ADDR_W-1:0] RF_INADDRESS,
    output logic [DATA_W-1:0] RF_IN,
    output logic [NREG-1:0]   PENDING,
    output logic [7:0]        CONFLICTS
);

    // Round-robin pointer: 1 means MEM won the last contested cycle.
    logic              last_mem_q, last_mem_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic [7:0]        conflicts_q, conflicts_d;

    logic              contested;
    logic              alu_grant;
    logic              mem_grant;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;

    // Grant selection and hazard detection; readies are forced low during reset.
    always_comb begin
        contested = ALU_VALID & MEM_VALID;
        alu_grant = ~RESET & ALU_VALID & (~MEM_VALID | last_mem_q);
        mem_grant = ~RESET & MEM_VALID & (~ALU_VALID | ~last_mem_q);
        // A committing register still stalls: the register file only samples it at the next edge.
        STALL     = pending_q[SRC1_ADDR] | pending_q[SRC2_ADDR] | (ISSUE & pending_q[ISSUE_ADDR]);
    end

    // Next-state for pointer, commit stage, scoreboard and conflict counter.
    always_comb begin
        last_mem_d  = last_mem_q;
        rf_write_d  = alu_grant | mem_grant;
        rf_addr_d   = rf_addr_q;
        rf_data_d   = rf_data_q;
        conflicts_d = conflicts_q;
        set_mask    = '0;
        clr_mask    = '0;

        if (contested) begin
            last_mem_d = mem_grant;
        end

        if (alu_grant) begin
            rf_addr_d = ALU_ADDR;
            rf_data_d = ALU_DATA;
        end else if (mem_grant) begin
            rf_addr_d = MEM_ADDR;
            rf_data_d = MEM_DATA;
        end

        if (rf_write_q) begin
            clr_mask = NREG'(1) << rf_addr_q;
        end
        if (ISSUE && !STALL) begin
            set_mask = NREG'(1) << ISSUE_ADDR;
        end
        // Set wins over clear: a new writer is already in flight for that register.
        pending_d = (pending_q & ~clr_mask) | set_mask;

        if (contested && conflicts_q != 8'hFF) begin
            conflicts_d = conflicts_q + 8'd1;
        end
    end

    // State registers with synchronous reset; reset also drops any in-flight commit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_mem_q  <= 1'b1;
            rf_write_q  <= 1'b0;
            rf_addr_q   <= '0;
            rf_data_q   <= '0;
            pending_q   <= '0;
            conflicts_q <= '0;
        end else begin
            last_mem_q  <= last_mem_d;
            rf_write_q  <= rf_write_d;
            rf_addr_q   <= rf_addr_d;
            rf_data_q   <= rf_data_d;
            pending_q   <= pending_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign ALU_READY    = alu_grant;
    assign MEM_READY    = mem_grant;
    assign RF_WRITE     = rf_write_q;
    assign RF_INADDRESS = rf_addr_q;
    assign RF_IN        = rf_data_q;
    assign PENDING      = pending_q;
    assign CONFLICTS    = conflicts_q;

endmodule
